// File: rtl/bsg_tx_serializer_pkg.sv
// Shared types and CTRL field positions for the BSG transmit serializer.
// Parity support is enabled by defining BSG_PARITY_EN.
package bsg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_B,
    DATA,
    PARITY,
    STOP
  } bsg_tx_state_t;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MSB     = 1;
  localparam int CTRL_TWO     = 2;
  localparam int CTRL_DIV_LSB = 4;

endpackage

// File: rtl/bsg_tx_serializer_if.sv
// Register-bank side and serial-line side of the BSG transmit serializer.
// The register bank drives master; the serializer is the slave.
interface bsg_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] CTRL_IN;
  logic [DATA_WIDTH-1:0] DATA0_IN;
  logic [DATA_WIDTH-1:0] DATA1_IN;
  logic                  START;
  logic                  READY;
  logic                  BUSY;
  logic                  TX_OUT;
  logic                  TX_STROBE;
  logic                  DONE;

  modport master (
    output CTRL_IN,
    output DATA0_IN,
    output DATA1_IN,
    output START,
    input  READY,
    input  BUSY,
    input  TX_OUT,
    input  TX_STROBE,
    input  DONE
  );

  modport slave (
    input  CTRL_IN,
    input  DATA0_IN,
    input  DATA1_IN,
    input  START,
    output READY,
    output BUSY,
    output TX_OUT,
    output TX_STROBE,
    output DONE
  );

endinterface

// File: rtl/bsg_baud_counter.sv
// Bit-period down-counter: flags the first and last cycle of every bit.
// Reloads on each tick and whenever a new transfer is accepted.
module bsg_baud_counter #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 bit_tick,
  output logic                 bit_first
);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      if (cnt == '0) cnt <= load_val;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign bit_tick  = run && (cnt == '0);
  assign bit_first = run && (cnt == load_val);

endmodule

// File: rtl/bsg_tx_serializer.sv
// Framed serial transmitter for BSG_DATA_0/1 (start, data, parity, stop).
// Define BSG_PARITY_EN to insert an even-parity bit before each stop bit.
import bsg_pkg::*;

module bsg_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 4
) (
  input  logic                  G_CLK_TX,
  input  logic                  rst,
  bsg_tx_serializer_if.slave    bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  bsg_tx_state_t         state, state_nxt;
  logic [DATA_WIDTH-1:0] ctrl_q, d0_q, d1_q;
  logic                  word_q, word_nxt;
  logic [CW-1:0]         bit_q, bit_nxt;
  logic                  done_q, done_nxt;
  logic                  accept, tick, first;
  logic [DIV_WIDTH-1:0]  div_ld;
  logic [DATA_WIDTH-1:0] word;
  logic [CW-1:0]         idx;
  logic                  tx;
  logic                  unused_ctrl;

  assign accept = (state == IDLE) && bus.START
               && bus.CTRL_IN[CTRL_EN];

  // A fresh transfer must start from the incoming period, not the old shadow
  assign div_ld = accept
    ? bus.CTRL_IN[CTRL_DIV_LSB +: DIV_WIDTH]
    : ctrl_q[CTRL_DIV_LSB +: DIV_WIDTH];

  bsg_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk       (G_CLK_TX),
    .rst_n     (rst),
    .load      (accept),
    .run       (state != IDLE),
    .load_val  (div_ld),
    .bit_tick  (tick),
    .bit_first (first)
  );

  always_ff @(posedge G_CLK_TX or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ctrl_q <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      word_q <= 1'b0;
      bit_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      word_q <= word_nxt;
      bit_q  <= bit_nxt;
      done_q <= done_nxt;
      if (accept) begin
        ctrl_q <= bus.CTRL_IN;
        d0_q   <= bus.DATA0_IN;
        d1_q   <= bus.DATA1_IN;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    bit_nxt   = bit_q;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START_B;
          word_nxt  = 1'b0;
          bit_nxt   = '0;
        end
      end
      START_B: begin
        if (tick) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == CW'(DATA_WIDTH - 1)) begin
`ifdef BSG_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end
      end
`ifdef BSG_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (ctrl_q[CTRL_TWO] && !word_q) begin
            state_nxt = START_B;
            word_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign word = word_q ? d1_q : d0_q;
  assign idx  = ctrl_q[CTRL_MSB]
    ? CW'(DATA_WIDTH - 1) - bit_q
    : bit_q;

  always_comb begin
    tx = 1'b1;
    unique case (state)
      START_B: tx = 1'b0;
      DATA:    tx = word[idx];
`ifdef BSG_PARITY_EN
      PARITY:  tx = ^word;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign unused_ctrl   = ^ctrl_q;
  assign bus.READY     = (state == IDLE);
  assign bus.BUSY      = (state != IDLE);
  assign bus.TX_OUT    = tx;
  assign bus.TX_STROBE = first;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_bsg_tx_serializer.sv
// Self-checking bench for bsg_tx_serializer against a bit-list frame model.
// Honours BSG_PARITY_EN the same way as the design.
module tb_bsg_tx_serializer;

  localparam int W  = 8;
  localparam int DW = 4;
`ifdef BSG_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bsg_tx_serializer_if #(.DATA_WIDTH(W)) bus ();

  bsg_tx_serializer #(
    .DATA_WIDTH (W),
    .DIV_WIDTH  (DW)
  ) dut (
    .G_CLK_TX (clk),
    .rst      (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  bit exp_tx[$];
  bit exp_st[$];

  // Expected line per cycle: every bit of the frame held DIV+1 cycles
  function automatic void build(input logic [7:0] c,
                                input logic [7:0] d0,
                                input logic [7:0] d1);
    bit bits[$];
    logic [7:0] wd;
    int nw;
    int per;
    exp_tx.delete();
    exp_st.delete();
    nw  = c[2] ? 2 : 1;
    per = int'(c[7:4]) + 1;
    for (int w = 0; w < nw; w++) begin
      wd = (w == 0) ? d0 : d1;
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        bits.push_back(wd[c[1] ? 7 - k : k]);
`ifdef BSG_PARITY_EN
      bits.push_back(^wd);
`endif
      bits.push_back(1'b1);
    end
    foreach (bits[b])
      for (int r = 0; r < per; r++) begin
        exp_tx.push_back(bits[b]);
        exp_st.push_back(r == 0);
      end
  endfunction

  task automatic send(input logic [7:0] c,
                      input logic [7:0] d0,
                      input logic [7:0] d1);
    bus.CTRL_IN  = c;
    bus.DATA0_IN = d0;
    bus.DATA1_IN = d1;
    bus.START    = 1'b1;
    @(negedge clk);
    bus.START    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.CTRL_IN = '0; bus.DATA0_IN = '0;
    bus.DATA1_IN = '0; bus.START = 1'b0;
    #2;
    total++;
    if ({bus.TX_OUT, bus.READY, bus.BUSY,
         bus.TX_STROBE, bus.DONE} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_state got tx/rdy/busy/st/done=%b want 11000",
        {bus.TX_OUT, bus.READY, bus.BUSY, bus.TX_STROBE, bus.DONE});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send(8'h01, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.TX_OUT, bus.READY, bus.BUSY, bus.DONE} !== 4'b1100) begin
      bad++;
      $display("FAIL async_reset got tx/rdy/busy/done=%b want 1100",
        {bus.TX_OUT, bus.READY, bus.BUSY, bus.DONE});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [10:0] cap;
    cap = '0;
    build(8'h01, 8'hA5, 8'h00);
    @(negedge clk);
    send(8'h01, 8'hA5, 8'h00);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i > 0) @(negedge clk);
      cap = {cap[9:0], bus.TX_OUT};
      total++;
      if (bus.TX_OUT !== exp_tx[i] || bus.TX_STROBE !== exp_st[i] ||
          bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
        bad++;
        $display("FAIL single c%0d tx=%b st=%b busy=%b done=%b want %b %b 1 0",
          i, bus.TX_OUT, bus.TX_STROBE, bus.BUSY, bus.DONE,
          exp_tx[i], exp_st[i]);
      end
    end
    total++;
`ifdef BSG_PARITY_EN
    if (cap !== 11'b01010010101) begin
`else
    if (cap[9:0] !== 10'b0101001011) begin
`endif
      bad++;
      $display("FAIL single_seq got %b", cap);
    end
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b1 || bus.READY !== 1'b1 || bus.TX_OUT !== 1'b1) begin
      bad++;
      $display("FAIL single_done done=%b rdy=%b tx=%b want 1 1 1",
        bus.DONE, bus.READY, bus.TX_OUT);
    end
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got %b want 0", bus.DONE);
    end
  endtask

  task automatic test_two_word();
    int strobes;
    int busy_n;
    int dones;
    strobes = 0; busy_n = 0; dones = 0;
    build(8'h27, 8'h80, 8'h01);
    @(negedge clk);
    send(8'h27, 8'h80, 8'h01);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i > 0) @(negedge clk);
      strobes += int'(bus.TX_STROBE);
      busy_n  += int'(bus.BUSY);
      dones   += int'(bus.DONE);
      total++;
      if (bus.TX_OUT !== exp_tx[i] || bus.TX_STROBE !== exp_st[i]) begin
        bad++;
        $display("FAIL two_word c%0d tx=%b st=%b want %b %b",
          i, bus.TX_OUT, bus.TX_STROBE, exp_tx[i], exp_st[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      busy_n += int'(bus.BUSY);
      dones  += int'(bus.DONE);
    end
    total++;
    if (strobes != 2 * (10 + PB) || busy_n != 6 * (10 + PB) || dones != 1) begin
      bad++;
      $display("FAIL two_word_count strobes=%0d busy=%0d done=%0d want %0d %0d 1",
        strobes, busy_n, dones, 2 * (10 + PB), 6 * (10 + PB));
    end
  endtask

  task automatic test_ignore();
    logic bad_idle;
    bad_idle = 1'b0;
    @(negedge clk);
    bus.CTRL_IN = 8'h00; bus.START = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.READY !== 1'b1 || bus.TX_OUT !== 1'b1 || bus.DONE !== 1'b0)
        bad_idle = 1'b1;
    end
    bus.START = 1'b0;
    total++;
    if (bad_idle) begin
      bad++;
      $display("FAIL disabled_start moved rdy=%b tx=%b want 1 1",
        bus.READY, bus.TX_OUT);
    end
    build(8'h11, 8'h5A, 8'h00);
    send(8'h11, 8'h5A, 8'h00);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (bus.TX_OUT !== exp_tx[i] || bus.TX_STROBE !== exp_st[i]) begin
        bad++;
        $display("FAIL noise c%0d tx=%b st=%b want %b %b",
          i, bus.TX_OUT, bus.TX_STROBE, exp_tx[i], exp_st[i]);
      end
      bus.START    = 1'($urandom);
      bus.CTRL_IN  = 8'($urandom);
      bus.DATA0_IN = 8'($urandom);
      bus.DATA1_IN = 8'($urandom);
    end
    bus.START = 1'b0;
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b1) begin
      bad++;
      $display("FAIL noise_done got %b want 1", bus.DONE);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    send(8'h01, 8'hFF, 8'h00);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset tx=%b busy=%b want 1 0", bus.TX_OUT, bus.BUSY);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.DONE !== 1'b0 || bus.TX_OUT !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_reset_quiet got done/activity want none");
    end
    build(8'h01, 8'h3C, 8'h00);
    send(8'h01, 8'h3C, 8'h00);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (bus.TX_OUT !== exp_tx[i] || bus.TX_STROBE !== exp_st[i]) begin
        bad++;
        $display("FAIL after_reset c%0d tx=%b st=%b want %b %b",
          i, bus.TX_OUT, bus.TX_STROBE, exp_tx[i], exp_st[i]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.DONE !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_done got %b want 1", bus.DONE);
    end
  endtask

  task automatic test_parity();
    logic [10:0] cap;
    int len;
    cap = '0;
    len = 0;
    @(negedge clk);
    send(8'h01, 8'h07, 8'h00);
    while (bus.DONE !== 1'b1 && len < 40) begin
      cap = {cap[9:0], bus.TX_OUT};
      len++;
      @(negedge clk);
    end
    total++;
`ifdef BSG_PARITY_EN
    if (len != 11 || cap !== 11'b01110000011) begin
`else
    if (len != 10 || cap[9:0] !== 10'b0111000001) begin
`endif
      bad++;
      $display("FAIL parity_frame len=%0d bits=%b want len %0d", len, cap, 10 + PB);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, d0, d1;
    @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      c  = {4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b1};
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      build(c, d0, d1);
      send(c, d0, d1);
      for (int i = 0; i < exp_tx.size(); i++) begin
        if (i > 0) @(negedge clk);
        total++;
        if (bus.TX_OUT !== exp_tx[i] || bus.TX_STROBE !== exp_st[i] ||
            bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
          bad++;
          $display("FAIL b2b f%0d c%0d tx=%b st=%b busy=%b want %b %b 1",
            f, i, bus.TX_OUT, bus.TX_STROBE, bus.BUSY, exp_tx[i], exp_st[i]);
        end
      end
      @(negedge clk);
      total++;
      if (bus.DONE !== 1'b1 || bus.READY !== 1'b1) begin
        bad++;
        $display("FAIL b2b_done f%0d done=%b rdy=%b want 1 1",
          f, bus.DONE, bus.READY);
      end
    end
    @(negedge clk);
    total++;
    if (bus.READY !== 1'b1 || bus.DONE !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle rdy=%b done=%b want 1 0", bus.READY, bus.DONE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_word();
    test_ignore();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
